// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared constants for the mips_mem unified program/data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = 8;
    localparam logic [ADDR_W-1:0] EXIT_ADDR_DEFAULT = 8'hFF;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] MEMST_LOAD = 2'd0;
    localparam logic [ST_W-1:0] MEMST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] MEMST_HALT = 2'd2;

    // Word fetches are aligned; the low two address bits are dropped.
    function automatic logic [ADDR_W-1:0] word_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage : mips_mem_pkg
`default_nettype wire

// File: rtl/byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : byte_ram
// Description : 256x8 RAM, one write port, registered big-endian word read
//               and registered byte read (read-before-write on collision).
// Revision    : 1.0 - initial release
// ============================================================================
module byte_ram
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_word_addr,
    input  logic [ADDR_W-1:0] i_byte_addr,
    output logic [31:0]       o_word,
    output logic [7:0]        o_byte
);

    logic [7:0]        r_mem [DEPTH];
    logic [31:0]       r_word;
    logic [7:0]        r_byte;
    logic [ADDR_W-1:0] w_b0;
    logic [ADDR_W-1:0] w_b1;
    logic [ADDR_W-1:0] w_b2;
    logic [ADDR_W-1:0] w_b3;

    assign w_b0 = word_base(i_word_addr);
    assign w_b1 = w_b0 + 8'd1;
    assign w_b2 = w_b0 + 8'd2;
    assign w_b3 = w_b0 + 8'd3;

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= 32'd0;
            r_byte <= 8'd0;
        end else begin
            r_word <= {r_mem[w_b0], r_mem[w_b1], r_mem[w_b2], r_mem[w_b3]};
            r_byte <= r_mem[i_byte_addr];
        end
    end

    assign o_word = r_word;
    assign o_byte = r_byte;

endmodule : byte_ram
`default_nettype wire

// File: rtl/mips_mem.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem
// Description : Unified program/data memory for the mips core with host image
//               loader, core reset control and exit-code capture.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem
    import mips_mem_pkg::*;
#(
    parameter int                DEPTH     = MEM_DEPTH,
    parameter logic [ADDR_W-1:0] EXIT_ADDR = EXIT_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] mem_i_addr,
    output logic [31:0]       mem_i,
    input  logic [ADDR_W-1:0] mem_rw_addr,
    input  logic [7:0]        mem_w,
    input  logic              mem_w_en,
    input  logic              breq,
    output logic [7:0]        mem_r,
    output logic              core_rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    input  logic              ld_restart,
    output logic              halted,
    output logic [7:0]        exit_code
);

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_core_rst;
    logic              r_halted;
    logic [7:0]        r_exit_code;

    logic              w_hs;
    logic              w_core_store;
    logic              w_exit_store;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [7:0]        w_wdata;

    assign w_hs         = (r_state == MEMST_LOAD) && ld_valid;
    assign w_core_store = (r_state == MEMST_RUN) && breq && mem_w_en;
    assign w_exit_store = w_core_store && (mem_rw_addr == EXIT_ADDR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MEMST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; restart takes priority over every other transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MEMST_LOAD: begin
                if (!ld_restart && w_hs && (ld_last || (r_ptr == 8'hFF))) begin
                    w_next_state = MEMST_RUN;
                end
            end
            MEMST_RUN: begin
                if (ld_restart) begin
                    w_next_state = MEMST_LOAD;
                end else if (w_exit_store) begin
                    w_next_state = MEMST_HALT;
                end
            end
            MEMST_HALT: begin
                if (ld_restart) begin
                    w_next_state = MEMST_LOAD;
                end
            end
            default: w_next_state = MEMST_LOAD;
        endcase
    end

    // Output logic: loader handshake and write-source selection.
    always_comb begin
        ld_ready = 1'b0;
        w_we     = 1'b0;
        w_waddr  = r_ptr;
        w_wdata  = ld_data;
        case (r_state)
            MEMST_LOAD: begin
                ld_ready = 1'b1;
                w_we     = w_hs;
            end
            MEMST_RUN: begin
                w_we    = w_core_store;
                w_waddr = mem_rw_addr;
                w_wdata = mem_w;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= 8'd0;
            r_core_rst  <= 1'b1;
            r_halted    <= 1'b0;
            r_exit_code <= 8'd0;
        end else begin
            r_core_rst <= (w_next_state != MEMST_RUN);
            if (ld_restart) begin
                r_ptr <= 8'd0;
            end else if (w_hs && (r_ptr != 8'hFF)) begin
                r_ptr <= r_ptr + 8'd1;
            end
            if (ld_restart) begin
                r_halted    <= 1'b0;
                r_exit_code <= 8'd0;
            end else if (w_exit_store) begin
                r_halted    <= 1'b1;
                r_exit_code <= mem_w;
            end
        end
    end

    byte_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_word_addr (mem_i_addr),
        .i_byte_addr (mem_rw_addr),
        .o_word      (mem_i),
        .o_byte      (mem_r)
    );

    assign core_rst  = r_core_rst;
    assign halted    = r_halted;
    assign exit_code = r_exit_code;

endmodule : mips_mem
`default_nettype wire

// File: tb/tb_mips_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mem
// Description : Self-checking bench for mips_mem against a byte-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mem_i_addr;
    logic [31:0] mem_i;
    logic [7:0]  mem_rw_addr;
    logic [7:0]  mem_w;
    logic        mem_w_en;
    logic        breq;
    logic [7:0]  mem_r;
    logic        core_rst;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_restart;
    logic        halted;
    logic [7:0]  exit_code;

    int checks = 0;
    int passes = 0;

    logic [7:0] model [256];
    int         exp_ptr = 0;

    always #5 clk = ~clk;

    mips_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_i_addr  (mem_i_addr),
        .mem_i       (mem_i),
        .mem_rw_addr (mem_rw_addr),
        .mem_w       (mem_w),
        .mem_w_en    (mem_w_en),
        .breq        (breq),
        .mem_r       (mem_r),
        .core_rst    (core_rst),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_restart  (ld_restart),
        .halted      (halted),
        .exit_code   (exit_code)
    );

    function automatic logic [31:0] exp_word(input logic [7:0] a);
        logic [7:0] b;
        b = a & 8'hFC;
        return {model[b], model[b + 8'd1], model[b + 8'd2], model[b + 8'd3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        model[exp_ptr] = d;
        if (exp_ptr < 255) exp_ptr++;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({mem_i, mem_r, core_rst, ld_ready, halted, exit_code} !== {32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0})
            $display("FAIL reset_values got %h exp %h",
                     {mem_i, mem_r, core_rst, ld_ready, halted, exit_code},
                     {32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0});
        else passes++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_load_fetch();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'(i), i == 7);
            if (i == 6) begin
                checks++;
                if ({core_rst, ld_ready} !== 2'b11)
                    $display("FAIL load_pre_last got %b exp 11", {core_rst, ld_ready});
                else passes++;
            end
        end
        checks++;
        if ({core_rst, ld_ready} !== 2'b00)
            $display("FAIL load_to_run got %b exp 00", {core_rst, ld_ready});
        else passes++;
        mem_i_addr = 8'd4;
        tick();
        checks++;
        if (mem_i !== 32'h04050607) $display("FAIL fetch_4 got %h exp 04050607", mem_i);
        else passes++;
        mem_i_addr = 8'd6;
        tick();
        checks++;
        if (mem_i !== 32'h04050607) $display("FAIL fetch_6 got %h exp 04050607", mem_i);
        else passes++;
        mem_i_addr = 8'd1;
        tick();
        checks++;
        if (mem_i !== 32'h00010203) $display("FAIL fetch_1 got %h exp 00010203", mem_i);
        else passes++;
    endtask

    task automatic test_backpressure_full();
        ld_restart = 1'b1;
        tick();
        ld_restart = 1'b0;
        exp_ptr = 0;
        checks++;
        if ({ld_ready, core_rst, halted} !== 3'b110)
            $display("FAIL restart_from_run got %b exp 110", {ld_ready, core_rst, halted});
        else passes++;
        for (int i = 0; i < 256; i++) begin
            repeat ($urandom_range(0, 3)) begin
                ld_valid = 1'b0;
                ld_data  = 8'($urandom);
                tick();
            end
            if (i == 255) begin
                checks++;
                if ({ld_ready, core_rst} !== 2'b11)
                    $display("FAIL full_pre_last got %b exp 11", {ld_ready, core_rst});
                else passes++;
            end
            send_byte(8'($urandom), 1'b0);
        end
        checks++;
        if ({ld_ready, core_rst} !== 2'b00)
            $display("FAIL full_implied_last got %b exp 00", {ld_ready, core_rst});
        else passes++;
        for (int w = 0; w < 64; w++) begin
            mem_i_addr = 8'(w * 4) | 8'($urandom_range(0, 3));
            tick();
            checks++;
            if (mem_i !== exp_word(mem_i_addr))
                $display("FAIL full_image_word addr %h got %h exp %h", mem_i_addr, mem_i, exp_word(mem_i_addr));
            else passes++;
        end
    endtask

    task automatic test_store_load();
        logic [7:0] old;
        logic [7:0] a;
        logic [7:0] d;
        old = model[8'h40];
        breq = 1'b1; mem_w_en = 1'b1; mem_rw_addr = 8'h40; mem_w = 8'hA5;
        tick();
        model[8'h40] = 8'hA5;
        checks++;
        if (mem_r !== old) $display("FAIL rbw_collision got %h exp %h", mem_r, old);
        else passes++;
        mem_w_en = 1'b0;
        tick();
        checks++;
        if (mem_r !== 8'hA5) $display("FAIL load_40 got %h exp a5", mem_r);
        else passes++;
        for (int k = 0; k < 16; k++) begin
            a = 8'($urandom_range(0, 254));
            d = 8'($urandom);
            mem_rw_addr = a; mem_w = d; mem_w_en = 1'b1;
            tick();
            model[a] = d;
            mem_w_en = 1'b0;
            tick();
            checks++;
            if (mem_r !== d) $display("FAIL rand_store_load addr %h got %h exp %h", a, mem_r, d);
            else passes++;
            mem_i_addr = a;
            tick();
            checks++;
            if (mem_i !== exp_word(a)) $display("FAIL store_fetch addr %h got %h exp %h", a, mem_i, exp_word(a));
            else passes++;
        end
        breq = 1'b0;
    endtask

    task automatic test_ignored_strobe();
        logic [7:0] old;
        old = model[8'h10];
        breq = 1'b0; mem_w_en = 1'b1; mem_rw_addr = 8'h10; mem_w = ~old;
        tick();
        mem_w_en = 1'b0; breq = 1'b1;
        tick();
        checks++;
        if (mem_r !== old) $display("FAIL ignored_strobe got %h exp %h", mem_r, old);
        else passes++;
        breq = 1'b0;
    endtask

    task automatic test_exit();
        logic [7:0] old;
        checks++;
        if (halted !== 1'b0) $display("FAIL pre_exit_halted got %b exp 0", halted);
        else passes++;
        breq = 1'b1; mem_w_en = 1'b1; mem_rw_addr = 8'hFF; mem_w = 8'h2A;
        tick();
        model[8'hFF] = 8'h2A;
        checks++;
        if ({halted, exit_code, core_rst, ld_ready} !== {1'b1, 8'h2A, 1'b1, 1'b0})
            $display("FAIL exit_capture got %h exp %h", {halted, exit_code, core_rst, ld_ready},
                     {1'b1, 8'h2A, 1'b1, 1'b0});
        else passes++;
        old = model[8'h20];
        mem_rw_addr = 8'h20; mem_w = ~old;
        tick();
        mem_w_en = 1'b0;
        tick();
        checks++;
        if (mem_r !== old) $display("FAIL halt_frozen got %h exp %h", mem_r, old);
        else passes++;
        mem_rw_addr = 8'hFF;
        tick();
        checks++;
        if ({mem_r, halted, exit_code} !== {8'h2A, 1'b1, 8'h2A})
            $display("FAIL halt_held got %h exp %h", {mem_r, halted, exit_code}, {8'h2A, 1'b1, 8'h2A});
        else passes++;
        breq = 1'b0;
    endtask

    task automatic test_restart();
        logic [7:0] b0;
        logic [7:0] b1;
        ld_restart = 1'b1;
        tick();
        ld_restart = 1'b0;
        exp_ptr = 0;
        checks++;
        if ({halted, exit_code, ld_ready, core_rst} !== {1'b0, 8'h00, 1'b1, 1'b1})
            $display("FAIL restart_from_halt got %h exp %h", {halted, exit_code, ld_ready, core_rst},
                     {1'b0, 8'h00, 1'b1, 1'b1});
        else passes++;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b1);
        checks++;
        if (core_rst !== 1'b0) $display("FAIL restart_run got %b exp 0", core_rst);
        else passes++;
        mem_i_addr = 8'd0;
        tick();
        checks++;
        if (mem_i !== exp_word(8'd0)) $display("FAIL restart_word0 got %h exp %h", mem_i, exp_word(8'd0));
        else passes++;
        // Restart and exit store in the same cycle.
        breq = 1'b1; mem_w_en = 1'b1; mem_rw_addr = 8'hFF; mem_w = 8'h77; ld_restart = 1'b1;
        tick();
        ld_restart = 1'b0; mem_w_en = 1'b0;
        model[8'hFF] = 8'h77;
        exp_ptr = 0;
        checks++;
        if ({halted, ld_ready, core_rst, exit_code} !== {1'b0, 1'b1, 1'b1, 8'h00})
            $display("FAIL restart_wins got %h exp %h", {halted, ld_ready, core_rst, exit_code},
                     {1'b0, 1'b1, 1'b1, 8'h00});
        else passes++;
        tick();
        checks++;
        if (mem_r !== 8'h77) $display("FAIL restart_store_written got %h exp 77", mem_r);
        else passes++;
        breq = 1'b0;
    endtask

    task automatic test_async_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        ld_valid = 1'b1;
        ld_data  = 8'h99;
        #2;
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        #1;
        checks++;
        if ({mem_i, mem_r, core_rst, ld_ready, halted, exit_code} !== {32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0})
            $display("FAIL async_reset got %h exp %h",
                     {mem_i, mem_r, core_rst, ld_ready, halted, exit_code},
                     {32'd0, 8'd0, 1'b1, 1'b1, 1'b0, 8'd0});
        else passes++;
        tick();
        rst_n = 1'b1;
        exp_ptr = 0;
        send_byte(8'hC3, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b1);
        mem_i_addr = 8'd2;
        tick();
        checks++;
        if (mem_i !== 32'hC33C5AA5) $display("FAIL post_reset_load got %h exp c33c5aa5", mem_i);
        else passes++;
    endtask

    initial begin
        rst_n = 1'b1;
        mem_i_addr = 8'd0; mem_rw_addr = 8'd0; mem_w = 8'd0; mem_w_en = 1'b0; breq = 1'b0;
        ld_valid = 1'b0; ld_data = 8'd0; ld_last = 1'b0; ld_restart = 1'b0;
        #1 rst_n = 1'b0;
        test_reset();
        test_load_fetch();
        test_backpressure_full();
        test_store_load();
        test_ignored_strobe();
        test_exit();
        test_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_mips_mem
`default_nettype wire

// File: doc/mips_mem.md
# mips_mem

Unified 256-byte program/data memory that acts as the responder for the `mips` core's instruction-fetch port and byte data port. It also contains a host loader that streams a program image in over a valid/ready handshake while holding the core in reset. It captures an exit code when the program stores to a reserved address. It sits beside the core in the top level and drives the core's `rst`.

## Interface
- `DEPTH`, 256: memory size in bytes; address width is 8, fixed.
- `EXIT_ADDR`, 8'hFF: data-store address that halts the program.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `mem_i_addr` input 8: core fetch byte address; bits [1:0] ignored.
- `mem_i` output 32: fetched word, big-endian: {m[a], m[a+1], m[a+2], m[a+3]}, with a = {mem_i_addr[7:2], 2'b00}.
- `mem_rw_addr` input 8: core data byte address.
- `mem_w` input 8: core store data.
- `mem_w_en` input 1: core store strobe; honoured only when `breq`=1.
- `breq` input 1: core data access (load or store) in MA.
- `mem_r` output 8: load data.
- `core_rst` output 1: active-high synchronous reset for the core.
- `ld_valid` input 1: host byte valid.
- `ld_ready` output 1: loader accepts a byte.
- `ld_data` input 8: host byte.
- `ld_last` input 1: the accepted byte is the final byte of the image.
- `ld_restart` input 1: single-cycle pulse; re-enter LOAD.
- `halted` output 1: program wrote `EXIT_ADDR`.
- `exit_code` output 8: byte stored to `EXIT_ADDR`.

## Operation
- **States:** LOAD, RUN, HALT. Reset enters LOAD with load pointer 0.
- **LOAD:**
  - `ld_ready`=1 and `core_rst`=1.
  - A handshake (`ld_valid`&`ld_ready`) writes `ld_data` to m[ptr], then ptr+1.
  - LOAD→RUN when the handshake carries `ld_last`=1, or when it writes ptr=255; the second case is an implied last byte, and ptr does not wrap.
  - Core ports are ignored in LOAD; no core write occurs.
- **RUN:**
  - `ld_ready`=0 and `core_rst`=0.
  - A core store (`breq`&`mem_w_en`) writes `mem_w` to m[`mem_rw_addr`].
  - A store to `EXIT_ADDR` also writes memory, latches `exit_code`=`mem_w`, sets `halted`, and moves RUN→HALT.
- **HALT:** `core_rst`=1, `ld_ready`=0; memory is frozen and `exit_code`/`halted` are held.
- **Restart:** `ld_restart` in RUN or HALT → LOAD with ptr=0, `halted`=0, `exit_code`=0. `ld_restart` in LOAD resets ptr to 0; bytes already written remain.
- **Reads:** fetch and load reads occur every cycle in every state, regardless of `breq`.
- **Read/write collision:** a read in the same cycle as a write to the same byte returns the old data (read-before-write). This applies on both ports.
- **Uninitialised contents:** memory contents are not reset; contents never written are X.

## Timing
- **Read latency:** fetch and load both have one cycle of latency. Address presented in cycle N → `mem_i`/`mem_r` valid after edge N+1, held until the next edge. This matches the core's IF→ID and MA→WB registering; during a stall the core re-presents the same address and gets the same word.
- **Writes:** take effect at the edge ending the cycle in which they are presented.
- **`core_rst` register:** registered from next state. `core_rst` falls one edge after the final load handshake, so the core's first fetch of address 0 sees the completed image. It rises at the same edge that sets `halted`.
- **`ld_ready`:** combinational from the current state (LOAD).
- **Reset values (`rst_n` low, asynchronous):**
  - state=LOAD, ptr=0.
  - `mem_i`=0, `mem_r`=0.
  - `core_rst`=1, `ld_ready`=1.
  - `halted`=0, `exit_code`=0.
- **Reset mid-load:** an in-flight handshake is lost and ptr restarts at 0.
- **Simultaneous events:** `ld_restart` in the same cycle as an `EXIT_ADDR` store → restart wins; that store still writes memory, but `halted` stays 0.

## Structure
- **Shared defines header:**
  - state encodings `MEMST_LOAD`/`MEMST_RUN`/`MEMST_HALT`
  - `EXIT_ADDR` default
  - memory size constant
- **Sub-module `byte_ram`:**
  - 256×8 array
  - one write port
  - two registered read paths: a 32-bit aligned word and an 8-bit byte
- **Top logic:** `mips_mem` holds the FSM, load pointer, write-source mux (loader vs. core, selected by state), and exit capture.

## Test plan
- **Load then fetch:** load bytes 00 01 02 03 04 05 06 07 with `ld_last` on the eighth → `core_rst` falls one edge later; `mem_i_addr`=4 → `mem_i`=32'h04050607 next cycle; `mem_i_addr`=6 returns the same word.
- **Back-pressure and full image:** hold `ld_valid` low for random gaps → no spurious writes. Load 256 bytes without `ld_last` → RUN entered after byte 255.
- **Store/load:** in RUN, store 8'hA5 to 8'h40, then load 8'h40 → `mem_r`=A5 one cycle after the load address. A same-cycle read of 8'h40 during the store returns the old value.
- **Ignored strobe:** `mem_w_en`=1 with `breq`=0 → memory unchanged.
- **Exit:** store 8'h2A to 8'hFF → `halted`=1 and `exit_code`=2A after that edge, `core_rst`=1 at the same edge; subsequent stores are ignored.
- **Restart and reset:** `ld_restart` in HALT → LOAD, `halted`=0, ptr=0, `ld_ready`=1. Assert `rst_n` low mid-load, asynchronously between edges → all outputs at reset values immediately; the next load starts at address 0.
